// File: rtl/mul_pkg.sv
// Shared types for the multi-cycle multiply sequencer: op/state encodings and
// the ALU control code mapping the decoder uses to issue multiplies.
package mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULH   = 2'd1,
        OP_MULHSU = 2'd2,
        OP_MULHU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // ALU control codes 17..20 are MUL, MULH, MULHSU, MULHU in op_e order
    localparam logic [4:0] ALU_MUL    = 5'd17;
    localparam logic [4:0] ALU_MULH   = 5'd18;
    localparam logic [4:0] ALU_MULHSU = 5'd19;
    localparam logic [4:0] ALU_MULHU  = 5'd20;

    function automatic op_e alu_to_op(input logic [4:0] alu_ctl);
        logic [4:0] idx;
        idx = alu_ctl - ALU_MUL;
        return op_e'(idx[1:0]);
    endfunction

endpackage

// File: rtl/mul_seq.sv
// Radix-2 shift-add multiplier for the M-extension multiply group.
// Fixed 34-cycle latency from accept to done; flush aborts without a result.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start
// CALC   | 32 shift-add iterations on operand magnitudes
// FIX    | apply sign, select low/high word into out
// DONE   | done pulse; a new start may be accepted here with no bubble
module mul_seq
    import mul_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] out
);

    state_e            state, state_nx;
    op_e               op_q;
    logic              neg;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic [5:0]        cnt;

    logic              accept;
    logic              sgn1, sgn2;
    logic [XLEN-1:0]   mag1, mag2;
    logic [2*XLEN-1:0] prod;

    assign accept = start && !flush && (state == S_IDLE || state == S_DONE);

    always_comb begin
        sgn1 = 1'b0;
        sgn2 = 1'b0;
        sgn1 = (op_e'(op) == OP_MULH || op_e'(op) == OP_MULHSU) && in1[XLEN-1];
        sgn2 = (op_e'(op) == OP_MULH) && in2[XLEN-1];
        // negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude
        mag1 = sgn1 ? (~in1 + 1'b1) : in1;
        mag2 = sgn2 ? (~in2 + 1'b1) : in2;
        prod = neg ? (~acc + 1'b1) : acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = S_CALC;
            S_CALC:  if (cnt == 6'(XLEN - 1)) state_nx = S_FIX;
            S_FIX:   state_nx = S_DONE;
            S_DONE:  state_nx = accept ? S_CALC : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    assign busy = (state == S_CALC) || (state == S_FIX);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= OP_MUL;
            neg    <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            out    <= '0;
        end else if (accept) begin
            op_q   <= op_e'(op);
            neg    <= sgn1 ^ sgn2;
            acc    <= '0;
            mcand  <= {{XLEN{1'b0}}, mag1};
            mplier <= mag2;
            cnt    <= '0;
        end else if (state == S_CALC) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 6'd1;
        end else if (state == S_FIX && !flush) begin
            out <= (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed corner cases, flush, reset and
// back-to-back timing, plus random operations against a 64-bit arithmetic model.
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] in1, in2;
    logic        flush;
    logic        busy, done;
    logic [31:0] out;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_exp;

    mul_seq #(.XLEN(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .in1   (in1),
        .in2   (in2),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    always #5 clk = ~clk;

    // reference: sign/zero-extend to 64 bits and multiply modulo 2^64
    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (o == 2'd1 || o == 2'd2) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (o == 2'd1) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (o == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // issue one op from IDLE, check busy window, done timing and result
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        logic bad;
        op = o; in1 = a; in2 = b; start = 1'b1;
        step();
        start = 1'b0;
        bad = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            if (!(busy === 1'b1 && done === 1'b0)) bad = 1'b1;
            step();
        end
        chk({tag, "_busy_window"}, {31'b0, bad}, 32'd0);
        chk({tag, "_done"}, {30'b0, busy, done}, 32'd1);
        chk({tag, "_out"}, out, exp);
        last_exp = exp;
        step();
        chk({tag, "_after"}, {30'b0, busy, done}, 32'd0);
    endtask

    initial begin
        logic        bad;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        rst = 1'b1; start = 1'b0; op = 2'd0; in1 = '0; in2 = '0; flush = 1'b0;
        last_exp = '0;
        step(); step();
        chk("reset_outputs", {out[29:0], busy, done}, 32'd0);
        chk("reset_out", out, 32'd0);
        rst = 1'b0;
        step();
        chk("idle_after_reset", {30'b0, busy, done}, 32'd0);

        run_op("mul_7x6", 2'd0, 32'd7, 32'd6, 32'h0000002A);
        run_op("ones_mul",    2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        run_op("ones_mulh",   2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        run_op("ones_mulhsu", 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("ones_mulhu",  2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("mulh_min_min", 2'd1, 32'h80000000, 32'h80000000, 32'h40000000);
        run_op("mulh_min_one", 2'd1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF);

        // flush at T+10, with a competing start that must be dropped
        op = 2'd0; in1 = 32'd3; in2 = 32'd5; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 10; k++) step();
        flush = 1'b1; start = 1'b1;
        step();
        flush = 1'b0; start = 1'b0;
        chk("flush_busy_drop", {31'b0, busy}, 32'd0);
        bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
            step();
        end
        chk("flush_no_done", {31'b0, bad}, 32'd0);
        chk("flush_out_kept", out, last_exp);
        run_op("post_flush_2x2", 2'd0, 32'd2, 32'd2, 32'd4);

        // back-to-back with start held; operand noise during CALC must be ignored
        op = 2'd3; in1 = 32'h00010000; in2 = 32'h00010000; start = 1'b1;
        step();
        bad = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            if (!(busy === 1'b1 && done === 1'b0)) bad = 1'b1;
            op = 2'($urandom_range(0, 3)); in1 = $urandom; in2 = $urandom;
            step();
        end
        chk("b2b_busy1", {31'b0, bad}, 32'd0);
        chk("b2b_done1", {30'b0, busy, done}, 32'd1);
        chk("b2b_out1", out, 32'h00000001);
        op = 2'd3; in1 = 32'h00010000; in2 = 32'h00010000;
        step();
        bad = 1'b0;
        for (int k = 35; k <= 67; k++) begin
            if (!(busy === 1'b1 && done === 1'b0)) bad = 1'b1;
            step();
        end
        chk("b2b_busy2", {31'b0, bad}, 32'd0);
        chk("b2b_done2", {30'b0, busy, done}, 32'd1);
        chk("b2b_out2", out, 32'h00000001);
        start = 1'b0;
        step();
        chk("b2b_idle", {30'b0, busy, done}, 32'd0);
        last_exp = 32'h00000001;

        // asynchronous reset at T+20
        op = 2'd0; in1 = 32'd1234; in2 = 32'd5; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 20; k++) step();
        chk("pre_reset_busy", {31'b0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_flags", {30'b0, busy, done}, 32'd0);
        chk("async_reset_out", out, 32'd0);
        step(); step();
        rst = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy !== 1'b0 || done !== 1'b0 || out !== 32'd0) bad = 1'b1;
            step();
        end
        chk("no_done_after_reset", {31'b0, bad}, 32'd0);
        run_op("post_reset_9x9", 2'd0, 32'd9, 32'd9, 32'h00000051);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 6 == 0) ra = {ra[31], 31'h0};
            if (i % 8 == 1) rb = 32'h80000000;
            run_op("random", ro, ra, rb, ref_mul(ro, ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
# mul_seq

Multi-cycle sequencer for the M-extension multiply group (ALU control codes 17–20: MUL, MULH, MULHSU, MULHU). It replaces the single-cycle 32×32 array multiply with a radix-2 shift-add engine. It sits beside the ALU in the EX stage: the decoder issues a multiply with `start`, and the pipeline stalls on `busy`. The result is returned with a one-cycle `done` pulse.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk` input 1 — rising-edge clock.
- `rst` input 1 — asynchronous, active-high reset.
- `start` input 1 — request; sampled only when the block can accept.
- `op` input 2 — operation: 0 MUL (low word), 1 MULH (s×s high), 2 MULHSU (s×u high), 3 MULHU (u×u high).
- `in1` input 32 — rs1 operand.
- `in2` input 32 — rs2 operand.
- `flush` input 1 — synchronous abort from a pipeline flush.
- `busy` output 1 — operation in flight; the pipeline must stall.
- `done` output 1 — one-cycle pulse; `out` is valid.
- `out` output 32 — result; holds its value until the next accepted `start`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Accept condition: `start`=1 and state is IDLE or DONE.
- On accept:
  - Latch `op`.
  - Compute operand magnitudes: `in1` is signed for MULH and MULHSU; `in2` is signed for MULH only.
  - Record `neg` as sign(in1) XOR sign(in2), counting only operands treated as signed.
  - Clear the 64-bit accumulator and load the 6-bit iteration counter with 0.
- CALC (32 cycles): each cycle, if multiplier LSB = 1, add the multiplicand to the accumulator; shift the multiplicand left 1 and the multiplier right 1; increment the counter. Leave for FIX when the counter reaches 31.
- Width rules:
  - Magnitude of 0x80000000 is the unsigned value 0x80000000; no overflow.
  - The accumulator is 64 bits unsigned; the product never exceeds 2^64−1.
- FIX (1 cycle): if `neg`=1, the product becomes the 64-bit two's-complement negation. Register `out` as product[31:0] for MUL, otherwise product[63:32].
- DONE (1 cycle): `done`=1. Next state is CALC if a new start is accepted, else IDLE.
- No zero-operand early exit. Latency is fixed.
- `flush`=1: the next state is IDLE from any state. No `done` is issued and `out` is unchanged. Flush and start in the same cycle: flush wins and the start is dropped.
- `start` while CALC or FIX is ignored. The issuing stage must hold the request, which `busy` guarantees.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `out`=0, accumulator/counter=0.
- Start accepted at the end of cycle T:
  - `busy`=1 in cycles T+1..T+33 (CALC T+1..T+32, FIX T+33).
  - `done`=1 and `out` valid in cycle T+34; `busy`=0 in DONE.
- Throughput: a start accepted in the DONE cycle T+34 gives the next `done` at T+68. There is no idle bubble.
- `busy` and `done` are registered decodes of state, with no combinational path from `start`.
- Reset asserted mid-operation: all state clears immediately. No `done` follows reset release.

## Structure
- Package `mul_pkg` holds:
  - `typedef enum logic [1:0]` for op: MUL, MULH, MULHSU, MULHU.
  - `typedef enum logic [1:0]` for state: IDLE, CALC, FIX, DONE.
  - A localparam mapping ALU control codes 17–20 to the op enum, for the decoder.
- Single module, with no sub-module. The shift-add datapath and FSM fit in one file of about 200 lines.

## Test plan
- MUL 7 × 6 → `out`=0x0000002A, with `done` exactly at T+34 and `busy` high T+1..T+33.
- 0xFFFFFFFF × 0xFFFFFFFF under each op:
  - MUL → 0x00000001
  - MULH → 0x00000000
  - MULHSU → 0xFFFFFFFF
  - MULHU → 0xFFFFFFFE
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULH 0x80000000 × 0x00000001 → 0xFFFFFFFF.
- Start MUL 3 × 5, then assert `flush` at T+10:
  - `busy`=0 from T+11, no `done` pulse, `out` keeps its previous value.
  - Then start MUL 2 × 2 → `out`=4.
- Back-to-back: start MULHU 0x10000 × 0x10000 held through DONE:
  - First `done` at T+34 with `out`=0x00000001.
  - Second `done` at T+68.
  - `start` pulses during CALC are ignored.
- Assert `rst` asynchronously at T+20 of a MUL:
  - All outputs go to 0 immediately.
  - No `done` after release.
  - The next MUL 9 × 9 → 0x00000051.
